// File: rtl/sync_pkg.sv
// Shared helpers for the multi-channel synchroniser/debouncer: counter sizing
// and parameter legality checks evaluated at elaboration.
package sync_pkg;

  function automatic int unsigned cnt_width(input int unsigned filt_cycles);
    int unsigned w;
    w = (filt_cycles > 1) ? $clog2(filt_cycles) : 1;
    return w;
  endfunction

  function automatic bit params_ok(input int unsigned stages,
                                   input int unsigned filt_cycles,
                                   input int unsigned reset_bits,
                                   input int unsigned width);
    return (stages >= 2) && (filt_cycles >= 1) && (reset_bits == width);
  endfunction

endpackage

// File: rtl/sync_debounce_bit.sv
// One channel: STAGES-deep synchroniser, stability counter, accepted level and
// registered rise/fall pulses. Pulse next-state is exported for the top's OR.
module sync_debounce_bit
  import sync_pkg::*;
#(
  parameter int unsigned STAGES      = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_din,
  output logic o_dout,
  output logic o_rise,
  output logic o_fall,
  output logic o_rise_nxt,
  output logic o_fall_nxt
);

  localparam int unsigned CW = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);

  logic [STAGES-1:0] r_sync;
  logic [CW-1:0]     r_cnt;
  logic              r_dout;
  logic              r_rise;
  logic              r_fall;

  logic w_s;
  logic w_diff;
  logic w_accept;
  logic w_rise_nxt;
  logic w_fall_nxt;

  // r_sync[0] is the metastability-capture flop; its input is a timing false
  // path and the chain must stay a plain shift register (no merge/retime).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_din};
    end
  end

  always_comb begin
    w_s        = r_sync[STAGES-1];
    w_diff     = (w_s != r_dout);
    w_accept   = i_en && w_diff && (r_cnt == CNT_MAX);
    w_rise_nxt = w_accept && w_s;
    w_fall_nxt = w_accept && !w_s;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_dout <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
      if (i_en) begin
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_dout <= w_s;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign o_dout     = r_dout;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_rise_nxt = w_rise_nxt;
  assign o_fall_nxt = w_fall_nxt;

endmodule

// File: rtl/sync_debounce.sv
// WIDTH-channel input synchroniser with glitch filter and edge pulses; the
// top holds the per-channel instances and the registered any-edge flag.
module sync_debounce
  import sync_pkg::*;
#(
  parameter int unsigned     WIDTH       = 32,
  parameter int unsigned     STAGES      = 2,
  parameter int unsigned     FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  if (!params_ok(STAGES, FILT_CYCLES, $bits(RESET_VAL), WIDTH)) begin : g_param_err
    $error("sync_debounce: need STAGES>=2, FILT_CYCLES>=1, RESET_VAL width == WIDTH");
  end

  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] w_fall_nxt;
  logic             r_changed;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_debounce_bit #(
      .STAGES      (STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RESET_VAL   (RESET_VAL[i])
    ) u_bit (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_en       (en),
      .i_din      (din[i]),
      .o_dout     (dout[i]),
      .o_rise     (rise[i]),
      .o_fall     (fall[i]),
      .o_rise_nxt (w_rise_nxt[i]),
      .o_fall_nxt (w_fall_nxt[i])
    );
  end

  // Built from pulse next-state so it lands on the same cycle as rise/fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |(w_rise_nxt | w_fall_nxt);
    end
  end

  assign changed = r_changed;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce: three configurations (defaults,
// STAGES=3/FILT_CYCLES=1, WIDTH=8 with non-zero reset level).
module tb_sync_debounce;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // DUT a: defaults
  logic        en_a;
  logic [31:0] din_a, dout_a, rise_a, fall_a;
  logic        changed_a;

  // DUT b: STAGES=3, FILT_CYCLES=1
  logic        en_b;
  logic [3:0]  din_b, dout_b, rise_b, fall_b;
  logic        changed_b;

  // DUT c: WIDTH=8, RESET_VAL=0x0F
  logic        en_c;
  logic [7:0]  din_c, dout_c, rise_c, fall_c;
  logic        changed_c;

  sync_debounce u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .din(din_a),
    .dout(dout_a), .rise(rise_a), .fall(fall_a), .changed(changed_a)
  );

  sync_debounce #(.WIDTH(4), .STAGES(3), .FILT_CYCLES(1), .RESET_VAL(4'h0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .din(din_b),
    .dout(dout_b), .rise(rise_b), .fall(fall_b), .changed(changed_b)
  );

  sync_debounce #(.WIDTH(8), .STAGES(2), .FILT_CYCLES(4), .RESET_VAL(8'h0F)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .din(din_c),
    .dout(dout_c), .rise(rise_c), .fall(fall_c), .changed(changed_c)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [31:0] st_a;
  logic        st_ch_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance n edges, sampling 1ns after each; accumulates DUT a pulse activity.
  task automatic cyc(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      st_a    = st_a | rise_a | fall_a;
      st_ch_a = st_ch_a | changed_a;
    end
  endtask

  task automatic clr_sticky();
    st_a    = '0;
    st_ch_a = 1'b0;
  endtask

  initial begin
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    din_a = '0; din_b = '0; din_c = 8'h00;
    clr_sticky();
    cyc(3);

    // Reset values
    chk("rst_dout_a", dout_a, 32'h0);
    chk("rst_dout_c", 32'(dout_c), 32'h0F);
    chk("rst_chg_c", 32'(changed_c), 32'h0);

    // Release; din_c steps 0x00 -> 0xA5 at the same moment
    rst_n = 1'b1;
    din_c = 8'hA5;
    clr_sticky();
    cyc(5);
    chk("c_pre_dout", 32'(dout_c), 32'h0F);
    chk("c_pre_chg", 32'(changed_c), 32'h0);
    cyc(1);
    chk("c_dout", 32'(dout_c), 32'hA5);
    chk("c_rise", 32'(rise_c), 32'hA0);
    chk("c_fall", 32'(fall_c), 32'h0A);
    chk("c_chg", 32'(changed_c), 32'h1);
    cyc(1);
    chk("c_chg_off", 32'(changed_c), 32'h0);
    chk("c_pulse_off", 32'(rise_c | fall_c), 32'h0);
    cyc(14);
    chk("idle_dout_a", dout_a, 32'h0);
    chk("idle_pulse_a", st_a, 32'h0);
    chk("idle_chg_a", 32'(st_ch_a), 32'h0);

    // Step latency, defaults: update at E0+5
    din_a[0] = 1'b1;
    cyc(5);
    chk("step_dout_e4", dout_a, 32'h0);
    chk("step_rise_e4", rise_a, 32'h0);
    cyc(1);
    chk("step_dout_e5", dout_a, 32'h1);
    chk("step_rise_e5", rise_a, 32'h1);
    chk("step_fall_e5", fall_a, 32'h0);
    chk("step_chg_e5", 32'(changed_a), 32'h1);
    cyc(1);
    chk("step_rise_e6", rise_a, 32'h0);
    chk("step_chg_e6", 32'(changed_a), 32'h0);
    chk("step_dout_e6", dout_a, 32'h1);

    // Step latency, STAGES=3 FILT_CYCLES=1: update at E0+3
    din_b[2] = 1'b1;
    cyc(3);
    chk("b_dout_e2", 32'(dout_b), 32'h0);
    cyc(1);
    chk("b_dout_e3", 32'(dout_b), 32'h4);
    chk("b_rise_e3", 32'(rise_b), 32'h4);
    chk("b_chg_e3", 32'(changed_b), 32'h1);
    cyc(1);
    chk("b_rise_e4", 32'(rise_b), 32'h0);

    // Glitch of 3 cycles on din[5]: rejected
    clr_sticky();
    din_a[5] = 1'b1;
    cyc(3);
    din_a[5] = 1'b0;
    cyc(10);
    chk("glitch_dout", dout_a, 32'h1);
    chk("glitch_pulse", st_a, 32'h0);
    chk("glitch_chg", 32'(st_ch_a), 32'h0);

    // 5-cycle pulse on din[5]: accepted, then falls 5 cycles after release
    din_a[5] = 1'b1;
    cyc(5);
    din_a[5] = 1'b0;
    cyc(1);
    chk("p5_dout", dout_a, 32'h21);
    chk("p5_rise", rise_a, 32'h20);
    cyc(4);
    chk("p5_hold", dout_a, 32'h21);
    chk("p5_nofall", fall_a, 32'h0);
    cyc(1);
    chk("p5_fall", fall_a, 32'h20);
    chk("p5_dout_lo", dout_a, 32'h01);
    chk("p5_chg", 32'(changed_a), 32'h1);

    // Enable hold: freeze at cnt=2, resume, update after 2 enabled edges
    cyc(2);
    din_a[1] = 1'b1;
    cyc(4);
    en_a = 1'b0;
    clr_sticky();
    cyc(10);
    chk("en_hold_dout", dout_a, 32'h01);
    chk("en_hold_pulse", st_a, 32'h0);
    chk("en_hold_chg", 32'(st_ch_a), 32'h0);
    en_a = 1'b1;
    cyc(1);
    chk("en_resume1", dout_a, 32'h01);
    cyc(1);
    chk("en_resume2", dout_a, 32'h03);
    chk("en_rise", rise_a, 32'h02);

    // Reset mid-count on din[3]; bits 0,1,3 differ from reset level afterwards
    cyc(2);
    din_a[3] = 1'b1;
    cyc(3);
    rst_n = 1'b0;
    #2;
    chk("midrst_dout", dout_a, 32'h0);
    chk("midrst_pulse", rise_a | fall_a, 32'h0);
    cyc(1);
    rst_n = 1'b1;
    clr_sticky();
    cyc(5);
    chk("post_rst_dout", dout_a, 32'h0);
    chk("post_rst_quiet", st_a, 32'h0);
    cyc(1);
    chk("post_rst_acc", dout_a, 32'h0B);
    chk("post_rst_rise", rise_a, 32'h0B);
    chk("post_rst_chg", 32'(changed_a), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Parametrised multi-channel input synchroniser with per-channel glitch filter and edge detection. It brings WIDTH asynchronous level signals (status pins, flags from other clock domains) into the `clk` domain through a STAGES-deep flop chain. It accepts a new level only after it has been stable for FILT_CYCLES consecutive cycles, and reports accepted transitions as single-cycle rise/fall pulses. It replaces the fixed two-flop, no-reset synchroniser in new control-path logic.

## Interface
- WIDTH, 32: number of independent channels.
- STAGES, 2: synchroniser depth, minimum 2.
- FILT_CYCLES, 4: consecutive stable cycles required to accept a new level, minimum 1. A value of 1 means no filtering.
- RESET_VAL, {WIDTH{1'b0}}: per-channel reset level of the sync chain and `dout`.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  filter enable. When low, filter counters and `dout` hold; the sync chain keeps sampling.
- din  in  WIDTH  asynchronous level inputs.
- dout  out  WIDTH  filtered, synchronised levels.
- rise  out  WIDTH  one-cycle pulse when `dout[i]` goes 0→1.
- fall  out  WIDTH  one-cycle pulse when `dout[i]` goes 1→0.
- changed  out  1  one-cycle pulse when any bit of `rise` or `fall` is set.

## Operation
- Sync chain: STAGES flops per channel. `s[i]` is the last-stage output. All stages reset to RESET_VAL.
- Per-channel filter counter `cnt`, width `$clog2(FILT_CYCLES)` (minimum 1 bit), resets to 0.
- At each `clk` edge with `en`=1, per channel:
  - If `s==dout`: `cnt<=0`.
  - Else if `cnt==FILT_CYCLES-1`: `dout<=s`, `cnt<=0`, and either `rise` (s=1) or `fall` (s=0) is set for that cycle.
  - Else: `cnt<=cnt+1`.
- `en`=0: `cnt` and `dout` hold; `rise`, `fall` and `changed` are driven 0.
- A bounce back to the current `dout` level before the count completes clears `cnt`. The glitch is discarded and no pulse is produced.
- Channels are fully independent. Any number may pulse in the same cycle, and `changed` is the OR of them.
- `rise` and `fall` of one channel are never asserted together. A channel cannot pulse on two consecutive cycles unless FILT_CYCLES=1.
- Reset values:
  - `dout` = RESET_VAL.
  - `rise`, `fall`, `changed` = 0.
  - `cnt` = 0.
- Reset mid-count discards the pending transition. After reset release, a `din` that differs from RESET_VAL is accepted normally, with pulses, after the full latency.
- First-stage flops must be preserved and not replicated. Their inputs are constrained as asynchronous (false path on hold, relaxed setup), so synthesis must not merge or retime the chain.

## Timing
- All outputs are registered. There is no combinational path from `din` or `en` to any output.
- Latency: `din` stable before edge E0 → `dout` and pulse update at edge E0+STAGES+FILT_CYCLES-1. Example: defaults (2, 4) → update at E0+5.
- Minimum accepted pulse width on `din`: FILT_CYCLES+1 cycles, guaranteed. A pulse of FILT_CYCLES-1 or fewer cycles is always rejected.
- `en` takes effect on the same edge it is sampled. Deasserting `en` while `cnt` ≠ 0 freezes the count. Reasserting it resumes from the frozen value.

## Structure
- Shared package `sync_pkg`:
  - counter-width helper function;
  - elaboration checks: STAGES≥2, FILT_CYCLES≥1, RESET_VAL width = WIDTH.
- One sub-module, `sync_debounce_bit`: sync chain, counter, `dout`, `rise` and `fall` for a single channel, instantiated WIDTH times in a generate loop.
- The top level holds only the generate loop and the registered `changed` reduction. `changed` is computed from the per-bit pulse next-state so it aligns with `rise` and `fall`.

## Test plan
- Reset/idle:
  - Stimulus: defaults, RESET_VAL=0, `din`=0, release `rst_n`, run 20 cycles.
  - Required: `dout`=0, no pulses.
  - Then assert `rst_n`=0 mid-count (after `din[3]`=1 held 3 cycles). Required: `dout`, `cnt` and pulses cleared asynchronously, no pulse after release until 5 further cycles of `din[3]`=1.
- Step latency:
  - Stimulus: `din[0]` 0→1 before edge E0.
  - Required: `dout[0]`=1, `rise[0]`=1 and `changed`=1 exactly at E0+5, with pulses low at E0+6.
  - Repeat with STAGES=3, FILT_CYCLES=1. Required: update at E0+3.
- Glitch rejection:
  - Stimulus: `din[5]` high for 3 cycles, then low.
  - Required: `dout[5]` stays 0, no pulse.
  - Stimulus: high for 5 cycles. Required: accepted with `rise[5]`; return low yields `fall[5]` 5 cycles after the falling edge.
- Enable hold:
  - Stimulus: `din[1]`=1, drop `en` after `cnt` reaches 2, hold 10 cycles, reassert.
  - Required: `dout[1]` changes exactly 2 enabled cycles after reassertion, and no pulses while `en`=0.
- Simultaneous channels:
  - Stimulus: WIDTH=8, `din` 0x00→0xA5 in one cycle, with RESET_VAL=0x0F.
  - Required: after latency, `dout`=0xA5, `rise`=0xA0, `fall`=0x0A, `changed`=1 for exactly one cycle.
